// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared fetch-state encoding and constants for the byte-serial instruction fetch stage.
package ifetch_pkg;
    typedef enum logic [2:0] {FETCH0, FETCH1, FETCH2, FETCH3, PRESENT} fetch_state_e;
    localparam int          BYTES_PER_INSTR = 4;
    localparam logic [31:0] PC_STEP         = 32'd4;
    localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
endpackage

// File: rtl/ifetch_pc_npc_regs.sv
// ifetch_pc_npc_regs: PC/nPC delay-slot pair with pending-redirect capture.
// Optional IFETCH_MISALIGN_TRAP_EN adds a sticky misaligned-target flag.
module ifetch_pc_npc_regs
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        advance,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc_out,
    output logic [31:0] npc_out
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic        misalign_err
`endif
);
    logic [31:0] pc_q, pc_d, npc_q, npc_d, tgt_q, tgt_d, aligned;
    logic        pend_q, pend_d;

    assign aligned = redirect_target & ~32'h3;

    // A redirect on the advance edge bypasses the pending latch entirely.
    always_comb begin
        pc_d   = advance ? npc_q : pc_q;
        npc_d  = !advance ? npc_q : redirect ? aligned : pend_q ? tgt_q : npc_q + PC_STEP;
        pend_d = !advance && (redirect || pend_q);
        tgt_d  = (!advance && redirect) ? aligned : tgt_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q   <= RESET_PC;
            npc_q  <= RESET_PC + PC_STEP;
            tgt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            npc_q  <= npc_d;
            tgt_q  <= tgt_d;
            pend_q <= pend_d;
        end
    end

    assign pc_out  = pc_q;
    assign npc_out = npc_q;

`ifdef IFETCH_MISALIGN_TRAP_EN
    logic mis_q, mis_d;
    assign mis_d = mis_q || (redirect && redirect_target[1:0] != 2'b00);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) mis_q <= 1'b0;
        else        mis_q <= mis_d;
    end
    assign misalign_err = mis_q;
`endif
endmodule

// File: rtl/ifetch_byte_sequencer.sv
// ifetch_byte_sequencer: reads one big-endian instruction over 4 byte cycles and presents it to IF/ID.
// Optional IFETCH_MISALIGN_TRAP_EN exposes misalign_err.
module ifetch_byte_sequencer
    import ifetch_pkg::*;
#(
    parameter int          ADDR_W   = 9,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect,
    input  logic [31:0]       redirect_target,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       instr_out,
    output logic              instr_valid,
    output logic [31:0]       pc_out,
    output logic [31:0]       npc_out
`ifdef IFETCH_MISALIGN_TRAP_EN
    ,
    output logic              misalign_err
`endif
);
    fetch_state_e state_q, state_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d, advance;
    logic [1:0]   lane;

    assign advance = state_q == PRESENT && !stall;
    assign lane    = 2'(BYTES_PER_INSTR - 1) - state_q[1:0];

    always_comb begin
        instr_d = instr_q;
        if (state_q != PRESENT) instr_d[{lane, 3'b000} +: 8] = mem_rdata;
        state_d = state_q == PRESENT ? (stall ? PRESENT : FETCH0) :
                  state_q == FETCH3  ? PRESENT : fetch_state_e'(state_q + 3'd1);
        valid_d = state_q == FETCH3 || (state_q == PRESENT && stall);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Address depends only on registered state, so stall/redirect never reach memory combinationally.
    assign mem_addr    = pc_out[ADDR_W-1:0] + (state_q == PRESENT ? '0 : ADDR_W'(state_q[1:0]));
    assign instr_out   = instr_q;
    assign instr_valid = valid_q;

    ifetch_pc_npc_regs #(.RESET_PC(RESET_PC)) u_regs (
        .clk             (clk),
        .reset           (reset),
        .advance         (advance),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .pc_out          (pc_out),
        .npc_out         (npc_out)
`ifdef IFETCH_MISALIGN_TRAP_EN
        ,
        .misalign_err    (misalign_err)
`endif
    );
endmodule
